// File: rtl/sevenseg_scan.sv
// sevenseg_scan
//   Multiplexed hex display driver. NUM_DIGITS digits share one segment bus;
//   a refresh divider steps a digit index so that one digit enable is active
//   at a time. Each digit slot begins with GUARD_CYC blank cycles so the
//   previous digit's pattern cannot ghost onto the next anode. New display
//   data is double-buffered and committed only at the frame wrap, so a frame
//   never shows a mix of old and new values.
//
//   Optional feature (macro SEVENSEG_SCAN_LZ_BLANK_EN):
//     Leading-zero suppression. When the macro is defined, leading zero digits
//     are blanked at commit time. Digit 0 is never suppressed.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   value_i    hex nibbles, digit 0 = value_i[3:0] (rightmost)
//   load_i     one-cycle strobe, captures value_i and blank_i
//   blank_i    per-digit force-blank, captured with value_i
//   dp_i       per-digit decimal point, used live
//   seg_o      segments, seg_o[6]=a ... seg_o[0]=g
//   dp_o       decimal point pin
//   an_o       digit enables
//   pending_o  a loaded value is waiting for the frame boundary
//   frame_o    one-cycle pulse in the cycle after each frame wrap
//
// Handshake: load_i is a single-cycle strobe with no back-pressure. Every
// load is accepted. A load outside the wrap cycle lands in the shadow
// register and raises pending_o. A load in the wrap cycle goes straight to
// the display registers. The last load before the wrap wins.
module sevenseg_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 100000,
   parameter int GUARD_CYC      = 8,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic                    load_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    pending_o,
   output logic                    frame_o
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0]      GUARD_V  = DIV_W'(GUARD_CYC);
   localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   // Active-high abcdefg pattern for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h7E;
         4'h1: s = 7'h30;
         4'h2: s = 7'h6D;
         4'h3: s = 7'h79;
         4'h4: s = 7'h33;
         4'h5: s = 7'h5B;
         4'h6: s = 7'h5F;
         4'h7: s = 7'h70;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h7B;
         4'hA: s = 7'h77;
         4'hB: s = 7'h1F;
         4'hC: s = 7'h4E;
         4'hD: s = 7'h3D;
         4'hE: s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
   // Digit k is suppressed when it and every digit above it are zero.
   // Digit 0 is never suppressed.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] v);
      logic                  all_zero;
      logic [NUM_DIGITS-1:0] m;
      all_zero = 1'b1;
      m        = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero = all_zero & (v[4*k +: 4] == 4'h0);
         m[k]     = all_zero;
      end
      return m;
   endfunction
`endif

   // Scan state
   logic [DIV_W-1:0]        div;
   logic [IDX_W-1:0]        idx;
   logic                    slot_end;
   logic                    wrap;

   // Display and shadow data
   logic [4*NUM_DIGITS-1:0] disp_val;
   logic [NUM_DIGITS-1:0]   disp_blank;
   logic [4*NUM_DIGITS-1:0] pend_val;
   logic [NUM_DIGITS-1:0]   pend_blank;
   logic [4*NUM_DIGITS-1:0] commit_val;
   logic [NUM_DIGITS-1:0]   commit_blank;

   // Next output values
   logic [NUM_DIGITS-1:0]   sel;
   logic [3:0]              cur_nib;
   logic                    cur_blank;
   logic                    cur_dp;
   logic                    guard;
   logic [NUM_DIGITS-1:0]   an_nxt;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;

   assign slot_end = (div == DIV_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   // A load in the wrap cycle bypasses the shadow register.
   always_comb begin
      commit_val   = load_i ? value_i : pend_val;
      commit_blank = load_i ? blank_i : pend_blank;
`ifdef SEVENSEG_SCAN_LZ_BLANK_EN
      commit_blank = commit_blank | lz_mask(commit_val);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         idx <= '0;
      end else if (slot_end) begin
         div <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_val   <= '0;
         disp_blank <= '1;
         pend_val   <= '0;
         pend_blank <= '0;
         pending_o  <= 1'b0;
         frame_o    <= 1'b0;
      end else begin
         frame_o <= wrap;
         if (wrap) begin
            if (load_i || pending_o) begin
               disp_val   <= commit_val;
               disp_blank <= commit_blank;
            end
            pending_o <= 1'b0;
         end else if (load_i) begin
            pend_val   <= value_i;
            pend_blank <= blank_i;
            pending_o  <= 1'b1;
         end
      end
   end

   // Select the current digit's data with a compare per digit. This keeps
   // indexing in range for every NUM_DIGITS.
   always_comb begin
      sel       = '0;
      cur_nib   = 4'h0;
      cur_blank = 1'b1;
      cur_dp    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            sel[k]    = 1'b1;
            cur_nib   = disp_val[4*k +: 4];
            cur_blank = disp_blank[k];
            cur_dp    = dp_i[k];
         end
      end

      guard   = (div < GUARD_V);
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
      dp_nxt  = DP_OFF;
      if (!guard) begin
         an_nxt = (DIG_ACTIVE_LOW != 0) ? ~sel : sel;
         if (!cur_blank) begin
            seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~decode(cur_nib) : decode(cur_nib);
         end
         dp_nxt = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_o  <= AN_OFF;
         seg_o <= SEG_OFF;
         dp_o  <= DP_OFF;
      end else begin
         an_o  <= an_nxt;
         seg_o <= seg_nxt;
         dp_o  <= dp_nxt;
      end
   end

endmodule
